trng_req_arbiter: RTL and testbench

- Shares one bit-serial random-block generator among NUM_REQ requesters.
- Each requester asks for one GEN_WIDTH-bit random block over a req/gnt/rsp handshake.
- Grants are round-robin. The block sequences the generator's enable and clears the generator between blocks.
- Applies a repetition health test and a timeout. Sits between the entropy source and its consumers (key-gen, nonce, masking blocks).

---
 rtl/trng_req_arbiter_if.sv | 34 +++
 rtl/trng_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_trng_req_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// trng_req_arbiter_if : requester / generator bundle for the TRNG arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trng_req_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int GEN_WIDTH = 1024
);
   logic [NUM_REQ-1:0]   req_i;
   logic [NUM_REQ-1:0]   gnt_o;
   logic                 rsp_valid_o;
   logic [GEN_WIDTH-1:0] rsp_data_o;
   logic                 rsp_err_o;
   logic                 rsp_ready_i;
   logic                 gen_en_o;
   logic [GEN_WIDTH-1:0] gen_data_i;
   logic                 gen_valid_i;
   logic                 rep_fail_o;
   logic [7:0]           fail_cnt_o;

   modport slave (
      input  req_i, rsp_ready_i, gen_data_i, gen_valid_i,
      output gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, gen_en_o, rep_fail_o, fail_cnt_o
   );

   modport master (
      output req_i, rsp_ready_i, gen_data_i, gen_valid_i,
      input  gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, gen_en_o, rep_fail_o, fail_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/trng_req_arbiter.sv
// ---------------------------------------------------------------------------
// trng_req_arbiter : round-robin sharing of one random-block generator,
// with repetition health test, retry limit and generator timeout.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trng_req_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int GEN_WIDTH = 1024,
   parameter int TIMEOUT   = 2048,
   parameter int MAX_RETRY = 3
) (
   input  logic               clk,
   input  logic               rst,
   trng_req_arbiter_if.slave  arb_if
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GEN     = 2'd1,
      S_RELEASE = 2'd2,
      S_DELIVER = 2'd3
   } state_e;

   state_e               state_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [NUM_REQ-1:0]   gnt_d;
   logic [IDX_W-1:0]     ptr_q;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic                 rsp_valid_q;
   logic [GEN_WIDTH-1:0] rsp_data_q;
   logic                 rsp_err_q;
   logic                 gen_en_q;
   logic                 rep_fail_q;
   logic [7:0]           fail_cnt_q;
   logic [GEN_WIDTH-1:0] last_word_q;
   logic                 last_valid_q;
   logic [RTY_W-1:0]     retry_q;
   logic [TMR_W-1:0]     timer_q;

   // First requesting index after the previous winner, wrapping around.
   always_comb begin
      idx_d = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && arb_if.req_i[cand]) begin
            found = 1'b1;
            idx_d = cand;
         end
      end
      gnt_d = NUM_REQ'(1) << idx_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         gnt_q        <= '0;
         ptr_q        <= IDX_W'(NUM_REQ - 1);
         idx_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         gen_en_q     <= 1'b0;
         rep_fail_q   <= 1'b0;
         fail_cnt_q   <= '0;
         last_word_q  <= '0;
         last_valid_q <= 1'b0;
         retry_q      <= '0;
         timer_q      <= '0;
      end else begin
         rep_fail_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (|arb_if.req_i) begin
                  gnt_q    <= gnt_d;
                  idx_q    <= idx_d;
                  gen_en_q <= 1'b1;
                  timer_q  <= '0;
                  state_q  <= S_GEN;
               end
            end
            S_GEN: begin
               if (arb_if.gen_valid_i) begin
                  timer_q  <= '0;
                  gen_en_q <= 1'b0;
                  if (last_valid_q && (arb_if.gen_data_i == last_word_q)) begin
                     rep_fail_q <= 1'b1;
                     retry_q    <= retry_q + RTY_W'(1);
                     if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
                     if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_DELIVER;
                     end else begin
                        state_q <= S_RELEASE;
                     end
                  end else begin
                     last_word_q  <= arb_if.gen_data_i;
                     last_valid_q <= 1'b1;
                     retry_q      <= '0;
                     rsp_valid_q  <= 1'b1;
                     rsp_data_q   <= arb_if.gen_data_i;
                     rsp_err_q    <= 1'b0;
                     state_q      <= S_DELIVER;
                  end
               end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  // This cycle is the TIMEOUT-th spent waiting.
                  timer_q     <= '0;
                  gen_en_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
                  state_q     <= S_DELIVER;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            S_RELEASE: begin
               gen_en_q <= 1'b1;
               state_q  <= S_GEN;
            end
            S_DELIVER: begin
               if (arb_if.rsp_ready_i) begin
                  ptr_q       <= idx_q;
                  gnt_q       <= '0;
                  rsp_valid_q <= 1'b0;
                  retry_q     <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign arb_if.gnt_o       = gnt_q;
   assign arb_if.rsp_valid_o = rsp_valid_q;
   assign arb_if.rsp_data_o  = rsp_data_q;
   assign arb_if.rsp_err_o   = rsp_err_q;
   assign arb_if.gen_en_o    = gen_en_q;
   assign arb_if.rep_fail_o  = rep_fail_q;
   assign arb_if.fail_cnt_o  = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trng_req_arbiter : directed self-checking bench for trng_req_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trng_req_arbiter;

   localparam int GW = 1024;

   localparam logic [GW-1:0] BLK_A  = {(GW/32){32'h0123_4567}};
   localparam logic [GW-1:0] BLK_A5 = {(GW/32){32'hA5A5_A5A5}};
   localparam logic [GW-1:0] BLK_5A = {(GW/32){32'h5A5A_5A5A}};
   localparam logic [GW-1:0] BLK_C  = {(GW/32){32'hCAFE_F00D}};
   localparam logic [GW-1:0] BLK_D  = {(GW/32){32'hDEAD_BEEF}};

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int passed = 0;

   int             gen_lat = 2;
   int             gen_cnt = 0;
   logic [GW-1:0]  cur_blk = '0;
   logic [GW-1:0]  blk_q[$];

   trng_req_arbiter_if #(.NUM_REQ(4), .GEN_WIDTH(GW)) bus ();

   trng_req_arbiter #(
      .NUM_REQ(4), .GEN_WIDTH(GW), .TIMEOUT(2048), .MAX_RETRY(3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus.slave)
   );

   always #5 clk = ~clk;

   // Generator model: valid after gen_lat enabled cycles, drops when enable drops.
   initial begin
      bus.gen_valid_i = 1'b0;
      bus.gen_data_i  = '0;
      forever begin
         @(negedge clk);
         if (bus.gen_en_o) begin
            gen_cnt++;
            if (gen_cnt > gen_lat && !bus.gen_valid_i) begin
               if (blk_q.size() > 0) cur_blk = blk_q.pop_front();
               bus.gen_data_i  = cur_blk;
               bus.gen_valid_i = 1'b1;
            end
         end else begin
            gen_cnt         = 0;
            bus.gen_valid_i = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One transaction for a single requester; observations only, no checks.
   task automatic run_txn(input logic [3:0] r, output logic [3:0] g, output logic ok,
                          output logic [GW-1:0] d, output logic e, output int pulses,
                          output int enlow, output int enhigh);
      logic done;
      done = 1'b0; pulses = 0; enlow = 0; enhigh = 0;
      @(negedge clk);
      bus.req_i = r;
      @(negedge clk);
      bus.req_i = '0;
      g = bus.gnt_o;
      for (int k = 0; k < 6000 && !done; k++) begin
         if (bus.rep_fail_o) pulses++;
         if (bus.rsp_valid_o) done = 1'b1;
         else begin
            if (bus.gen_en_o) enhigh++; else enlow++;
            @(negedge clk);
         end
      end
      ok = done;
      d  = bus.rsp_data_o;
      e  = bus.rsp_err_o;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_i = '0;
      bus.rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", bus.gnt_o); else passed++;
      checks++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid_o); else passed++;
      checks++; if (bus.rsp_data_o !== '0) $display("FAIL reset_rsp_data: got nonzero expected 0"); else passed++;
      checks++; if (bus.rsp_err_o !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err_o); else passed++;
      checks++; if (bus.gen_en_o !== 1'b0) $display("FAIL reset_gen_en: got %b expected 0", bus.gen_en_o); else passed++;
      checks++; if (bus.rep_fail_o !== 1'b0) $display("FAIL reset_rep_fail: got %b expected 0", bus.rep_fail_o); else passed++;
      checks++; if (bus.fail_cnt_o !== 8'd0) $display("FAIL reset_fail_cnt: got %0d expected 0", bus.fail_cnt_o); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [3:0] g; logic ok; logic [GW-1:0] d; logic e; int p, lo, hi;
      gen_lat = 1024;
      blk_q.push_back(BLK_A);
      run_txn(4'b0010, g, ok, d, e, p, lo, hi);
      checks++; if (g !== 4'b0010) $display("FAIL single_gnt: got %b expected 0010", g); else passed++;
      checks++; if (ok !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", ok); else passed++;
      checks++; if (hi !== 1025) $display("FAIL single_gen_en_cycles: got %0d expected 1025", hi); else passed++;
      checks++; if (d !== BLK_A) $display("FAIL single_data: got %h expected %h", d[31:0], BLK_A[31:0]); else passed++;
      checks++; if (e !== 1'b0) $display("FAIL single_err: got %b expected 0", e); else passed++;
      checks++; if (bus.gnt_o !== 4'b0000) $display("FAIL single_gnt_after: got %b expected 0000", bus.gnt_o); else passed++;
      checks++; if (bus.gen_en_o !== 1'b0) $display("FAIL single_gen_en_after: got %b expected 0", bus.gen_en_o); else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      logic       got;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      gen_lat = 2;
      for (int k = 0; k < 5; k++) blk_q.push_back({(GW/32){32'hC0DE_0000 + 32'(k)}});
      @(negedge clk);
      bus.req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (bus.gnt_o !== exp_g[i]) $display("FAIL rr_gnt%0d: got %b expected %b", i, bus.gnt_o, exp_g[i]); else passed++;
         got = 1'b0;
         for (int k = 0; k < 50 && !got; k++) begin
            if (bus.rsp_valid_o) got = 1'b1; else @(negedge clk);
         end
         checks++; if (bus.rsp_data_o !== {(GW/32){32'hC0DE_0000 + 32'(i)}})
            $display("FAIL rr_data%0d: got %h expected %h", i, bus.rsp_data_o[31:0], 32'hC0DE_0000 + 32'(i));
         else passed++;
         bus.rsp_ready_i = 1'b1;
         @(negedge clk);
         bus.rsp_ready_i = 1'b0;
         if (i == 4) bus.req_i = '0;
         checks++; if (bus.gnt_o !== 4'b0000) $display("FAIL rr_idle%0d: got %b expected 0000", i, bus.gnt_o); else passed++;
      end
   endtask

   task automatic test_rep_fail();
      logic [3:0] g; logic ok; logic [GW-1:0] d; logic e; int p, lo, hi;
      do_reset();
      gen_lat = 2;
      blk_q.push_back(BLK_A5);
      blk_q.push_back(BLK_A5);
      blk_q.push_back(BLK_5A);
      run_txn(4'b0001, g, ok, d, e, p, lo, hi);
      checks++; if (d !== BLK_A5 || e !== 1'b0) $display("FAIL rep_first: got %h err %b expected %h err 0", d[31:0], e, BLK_A5[31:0]); else passed++;
      run_txn(4'b0001, g, ok, d, e, p, lo, hi);
      checks++; if (p !== 1) $display("FAIL rep_pulses: got %0d expected 1", p); else passed++;
      checks++; if (lo !== 1) $display("FAIL rep_en_low: got %0d expected 1", lo); else passed++;
      checks++; if (d !== BLK_5A || e !== 1'b0) $display("FAIL rep_regen: got %h err %b expected %h err 0", d[31:0], e, BLK_5A[31:0]); else passed++;
      checks++; if (bus.fail_cnt_o !== 8'd1) $display("FAIL rep_fail_cnt: got %0d expected 1", bus.fail_cnt_o); else passed++;
   endtask

   task automatic test_retry_exhaust();
      logic [3:0] g; logic ok; logic [GW-1:0] d; logic e; int p, lo, hi;
      do_reset();
      gen_lat = 2;
      blk_q.push_back(BLK_C);
      run_txn(4'b0100, g, ok, d, e, p, lo, hi);
      checks++; if (d !== BLK_C || e !== 1'b0) $display("FAIL exh_first: got %h err %b expected %h err 0", d[31:0], e, BLK_C[31:0]); else passed++;
      run_txn(4'b0100, g, ok, d, e, p, lo, hi);
      checks++; if (p !== 3) $display("FAIL exh_pulses: got %0d expected 3", p); else passed++;
      checks++; if (lo !== 2) $display("FAIL exh_en_low: got %0d expected 2", lo); else passed++;
      checks++; if (ok !== 1'b1 || e !== 1'b1) $display("FAIL exh_err: got valid %b err %b expected 1 1", ok, e); else passed++;
      checks++; if (d !== '0) $display("FAIL exh_data: got %h expected 0", d[31:0]); else passed++;
      checks++; if (bus.fail_cnt_o !== 8'd3) $display("FAIL exh_fail_cnt: got %0d expected 3", bus.fail_cnt_o); else passed++;
   endtask

   task automatic test_timeout();
      logic [3:0] g; logic ok; logic [GW-1:0] d; logic e; int p, lo, hi;
      gen_lat = 1_000_000;
      run_txn(4'b1000, g, ok, d, e, p, lo, hi);
      checks++; if (hi !== 2048) $display("FAIL to_gen_cycles: got %0d expected 2048", hi); else passed++;
      checks++; if (ok !== 1'b1 || e !== 1'b1 || d !== '0) $display("FAIL to_rsp: got valid %b err %b data %h expected 1 1 0", ok, e, d[31:0]); else passed++;
      checks++; if (p !== 0) $display("FAIL to_pulses: got %0d expected 0", p); else passed++;
      checks++; if (bus.fail_cnt_o !== 8'd4) $display("FAIL to_fail_cnt: got %0d expected 4", bus.fail_cnt_o); else passed++;
   endtask

   task automatic test_backpressure_reset();
      logic got;
      int   bad;
      gen_lat = 2;
      blk_q.push_back(BLK_D);
      @(negedge clk);
      bus.req_i = 4'b0100;
      @(negedge clk);
      bus.req_i = '0;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         if (bus.rsp_valid_o) got = 1'b1; else @(negedge clk);
      end
      checks++; if (got !== 1'b1) $display("FAIL bp_valid: got %b expected 1", got); else passed++;
      bad = 0;
      repeat (50) begin
         if (bus.rsp_data_o !== BLK_D || bus.gen_en_o !== 1'b0 || bus.rsp_valid_o !== 1'b1) bad++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) $display("FAIL bp_stable: got %0d bad cycles expected 0", bad); else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.gnt_o !== 4'b0000 || bus.rsp_valid_o !== 1'b0 || bus.gen_en_o !== 1'b0)
         $display("FAIL rst_ctrl: got gnt %b valid %b en %b expected 0000 0 0", bus.gnt_o, bus.rsp_valid_o, bus.gen_en_o);
      else passed++;
      checks++; if (bus.rsp_data_o !== '0 || bus.rsp_err_o !== 1'b0 || bus.fail_cnt_o !== 8'd0)
         $display("FAIL rst_data: got data %h err %b cnt %0d expected 0 0 0", bus.rsp_data_o[31:0], bus.rsp_err_o, bus.fail_cnt_o);
      else passed++;
      rst = 1'b0;
      bus.req_i = 4'b1111;
      @(negedge clk);
      bus.req_i = '0;
      checks++; if (bus.gnt_o !== 4'b0001) $display("FAIL rst_idle_gnt: got %b expected 0001", bus.gnt_o); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      bus.req_i = '0;
      bus.rsp_ready_i = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_rep_fail();
      test_retry_exhaust();
      test_timeout();
      test_backpressure_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
